// File: rtl/gdecoder32.sv
// Gray-count bus receiver: decodes to binary and classifies each step as hold, +1 or error.
// Optional saturating error counter enabled with `define GDEC_ERRCNT_EN.
module gdecoder32 #(
  parameter int unsigned W        = 32,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [W-1:0]        g_in,
  input  logic                g_valid,
  output logic [W-1:0]        bin_out,
  output logic                bin_valid,
  output logic                locked,
  output logic                step_ok,
  output logic                step_hold,
  output logic                step_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [0:0]   UNLOCKED = 1'b0;
  localparam logic [0:0]   LOCKED   = 1'b1;
  localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] g1;
  logic         v1;
  logic [0:0]   state;
  logic [W-1:0] ref_bin;
  logic [W-1:0] b;
  logic [W-1:0] ref_inc;
  logic         is_ok;
  logic         is_hold;
  logic         is_err;

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    b = '0;
    for (int i = 0; i < int'(W); i++) begin
      b[i] = ^(g1 >> i);
    end
  end

  always_comb begin
    ref_inc = ref_bin + ONE_W;
    is_ok   = (state == LOCKED) && (b == ref_inc);
    is_hold = (state == LOCKED) && (b == ref_bin) && !is_ok;
    is_err  = (state == LOCKED) && !is_ok && !is_hold;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      g1        <= '0;
      v1        <= 1'b0;
      state     <= UNLOCKED;
      ref_bin   <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      step_ok   <= 1'b0;
      step_hold <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      v1 <= g_valid;
      if (g_valid) begin
        g1 <= g_in;
      end
      bin_valid <= v1;
      step_ok   <= 1'b0;
      step_hold <= 1'b0;
      step_err  <= 1'b0;
      if (v1) begin
        // Always resync to the latest sample, even after an error.
        bin_out   <= b;
        ref_bin   <= b;
        state     <= LOCKED;
        step_ok   <= is_ok;
        step_hold <= is_hold;
        step_err  <= is_err;
      end
    end
  end

`ifdef GDEC_ERRCNT_EN
  localparam logic [ERRCNT_W-1:0] ONE_E = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if (v1 && is_err && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ONE_E;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_gdecoder32.sv
// Randomized and directed bench for gdecoder32 against a sample-level reference model.
module tb_gdecoder32;
  localparam int unsigned EW = 2;
`ifdef GDEC_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   g_in;
  logic          g_valid;
  logic [31:0]   bin_out;
  logic          bin_valid, locked, step_ok, step_hold, step_err;
  logic [EW-1:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: expected outputs after the next edge, last accepted value, sample in flight.
  logic [31:0]   e_bin, m_ref, pend_g;
  logic          e_bv, e_lk, e_ok, e_hold, e_err, pend_v;
  logic [EW-1:0] e_cnt;

  gdecoder32 #(.W(32), .ERRCNT_W(EW)) dut (
    .clk(clk), .reset(reset), .g_in(g_in), .g_valid(g_valid), .bin_out(bin_out),
    .bin_valid(bin_valid), .locked(locked), .step_ok(step_ok), .step_hold(step_hold),
    .step_err(step_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_gray(input logic [31:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [31:0] to_bin(input logic [31:0] g);
    logic [31:0] acc = '0;
    for (int s = 0; s < 32; s++) acc ^= (g >> s);
    return acc;
  endfunction

  // Apply one cycle of inputs, advance the model, and stop #1 after the edge.
  task automatic drive(input logic r, input logic v, input logic [31:0] g);
    logic [31:0] b, nxt;
    reset = r; g_valid = v; g_in = g;
    if (!r) begin
      e_bin = '0; e_bv = 0; e_lk = 0; e_ok = 0; e_hold = 0; e_err = 0; e_cnt = '0;
      m_ref = '0; pend_v = 0; pend_g = '0;
    end else begin
      e_bv = pend_v; e_ok = 0; e_hold = 0; e_err = 0;
      if (pend_v) begin
        b   = to_bin(pend_g);
        nxt = m_ref + 32'd1;
        if (e_lk) begin
          if (b == nxt) e_ok = 1;
          else if (b == m_ref) e_hold = 1;
          else begin
            e_err = 1;
            if (CNT_EN && e_cnt != {EW{1'b1}}) e_cnt = e_cnt + 1'b1;
          end
        end
        e_lk = 1; m_ref = b; e_bin = b;
      end
      pend_v = v; pend_g = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(0, 1, 32'h1234);
    drive(0, 0, 32'h0);
    n_chk++;
    if ({bin_out, bin_valid, locked, step_ok, step_hold, step_err, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset: got bin=%h v=%b lk=%b ok=%b h=%b e=%b cnt=%0d, need all 0",
               bin_out, bin_valid, locked, step_ok, step_hold, step_err, err_cnt);
    end
  endtask

  task automatic test_count;
    logic [31:0] gs [4] = '{32'h0, 32'h1, 32'h3, 32'h2};
    logic [31:0] bs [4] = '{32'h0, 32'h1, 32'h2, 32'h3};
    logic        ok [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    drive(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, i < 4, (i < 4) ? gs[i] : 32'h0);
      if (i >= 1 && i <= 4) begin
        n_chk++;
        if (bin_out !== bs[i-1] || step_ok !== ok[i-1] || !bin_valid || !locked) begin
          n_fail++;
          $display("FAIL count[%0d]: got bin=%h ok=%b v=%b lk=%b, need bin=%h ok=%b v=1 lk=1",
                   i - 1, bin_out, step_ok, bin_valid, locked, bs[i-1], ok[i-1]);
        end
      end else begin
        n_chk++;
        if (bin_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL count_idle[%0d]: got bin_valid=%b, need 0", i, bin_valid);
        end
      end
    end
  endtask

  task automatic test_wrap;
    drive(0, 0, 0);
    drive(1, 1, 32'h8000_0000);
    drive(1, 1, 32'h0000_0000);
    n_chk++;
    if (bin_out !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_top: got bin=%h, need ffffffff", bin_out);
    end
    drive(1, 0, 0);
    n_chk++;
    if (bin_out !== 32'h0 || step_ok !== 1'b1 || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_step: got bin=%h ok=%b err=%b, need bin=0 ok=1 err=0",
               bin_out, step_ok, step_err);
    end
  endtask

  task automatic test_skip;
    logic [EW-1:0] want = CNT_EN ? 2'd1 : 2'd0;
    drive(0, 0, 0);
    drive(1, 1, 32'h3);
    drive(1, 1, 32'h6);
    drive(1, 1, 32'h7);
    n_chk++;
    if (step_err !== 1'b1 || err_cnt !== want || bin_out !== 32'h4) begin
      n_fail++;
      $display("FAIL skip_err: got err=%b cnt=%0d bin=%h, need err=1 cnt=%0d bin=4",
               step_err, err_cnt, bin_out, want);
    end
    drive(1, 0, 0);
    n_chk++;
    if (step_ok !== 1'b1 || step_err !== 1'b0 || bin_out !== 32'h5) begin
      n_fail++;
      $display("FAIL skip_resync: got ok=%b err=%b bin=%h, need ok=1 err=0 bin=5",
               step_ok, step_err, bin_out);
    end
  endtask

  task automatic test_gap;
    drive(0, 0, 0);
    drive(1, 1, 32'h2);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'hDEAD_BEEF);
      n_chk++;
      if (bin_valid !== (i == 0) || bin_out !== 32'h3 || !locked ||
          (i > 0 && {step_ok, step_hold, step_err} !== 3'b000)) begin
        n_fail++;
        $display("FAIL gap[%0d]: got v=%b bin=%h lk=%b flags=%b%b%b", i, bin_valid, bin_out,
                 locked, step_ok, step_hold, step_err);
      end
    end
    drive(1, 1, 32'h2);
    drive(1, 1, 32'h6);
    n_chk++;
    if (step_hold !== 1'b1 || step_ok !== 1'b0 || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_hold: got hold=%b ok=%b err=%b, need hold=1", step_hold, step_ok,
               step_err);
    end
    drive(1, 0, 0);
    n_chk++;
    if (step_ok !== 1'b1 || bin_out !== 32'h4) begin
      n_fail++;
      $display("FAIL gap_ok: got ok=%b bin=%h, need ok=1 bin=4", step_ok, bin_out);
    end
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 0);
    drive(1, 1, 32'h5);
    drive(1, 1, 32'h4);
    drive(0, 1, 32'hC);
    n_chk++;
    if ({bin_out, bin_valid, locked, step_ok, step_hold, step_err, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got bin=%h v=%b lk=%b flags=%b%b%b, need all 0", bin_out,
               bin_valid, locked, step_ok, step_hold, step_err);
    end
    drive(1, 1, 32'h9);
    drive(1, 0, 0);
    n_chk++;
    if (locked !== 1'b1 || bin_valid !== 1'b1 || {step_ok, step_hold, step_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_relock: got lk=%b v=%b flags=%b%b%b, need lk=1 v=1 flags=000",
               locked, bin_valid, step_ok, step_hold, step_err);
    end
  endtask

  task automatic test_saturation;
    logic [EW-1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1, i < 6, to_gray(32'(i * 2)));
      if (i >= 2) begin
        n_chk++;
        if (err_cnt !== (CNT_EN ? want[i-2] : 2'd0) || step_err !== 1'b1) begin
          n_fail++;
          $display("FAIL sat[%0d]: got cnt=%0d err=%b, need cnt=%0d err=1", i - 2, err_cnt,
                   step_err, CNT_EN ? want[i-2] : 2'd0);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] cur = $urandom;
    logic [31:0] g;
    int          sel;
    drive(0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) cur = cur + 32'd1;
      else if (sel == 9) cur = $urandom;
      else if (sel == 8) cur = 32'hFFFF_FFFF;
      g = to_gray(cur);
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), g);
      n_chk++;
      if ({bin_out, bin_valid, locked, step_ok, step_hold, step_err, err_cnt} !==
          {e_bin, e_bv, e_lk, e_ok, e_hold, e_err, e_cnt}) begin
        n_fail++;
        $display("FAIL random[%0d]: got bin=%h v=%b lk=%b f=%b%b%b c=%0d, need bin=%h v=%b lk=%b f=%b%b%b c=%0d",
                 i, bin_out, bin_valid, locked, step_ok, step_hold, step_err, err_cnt,
                 e_bin, e_bv, e_lk, e_ok, e_hold, e_err, e_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b0; g_valid = 1'b0; g_in = '0;
    test_reset;
    test_count;
    test_wrap;
    test_skip;
    test_gap;
    test_reset_mid;
    test_saturation;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
